// File: rtl/idli_rf_m.sv
// idli_rf_m: serial-access register file feeding the 4b serial ALU.
// Holds NREGS x 16b registers (r0 reads zero) and streams operands a nibble
// per cycle, LSB nibble first, over a 4-cycle window with nibble write-back.
// Ports:
//   i_rf_gck / i_rf_rst      clock, synchronous active-high reset
//   i_rf_start               open a window; selects are latched with it
//   i_rf_lhs_sel/rhs_sel     operand source registers
//   i_rf_dst_sel, i_rf_wr_en destination register and write enable
//   i_rf_wdata               ALU result nibble for the current position
//   o_rf_lhs / o_rf_rhs      operand nibbles for the current position
//   o_rf_busy, o_rf_ctr      window active, nibble index 0..3
//   o_rf_ctr_last_cycle      ALU last-cycle strobe (high whenever idle)
module idli_rf_m #(
   parameter int NREGS = 8
) (
   input  logic                     i_rf_gck,
   input  logic                     i_rf_rst,
   input  logic                     i_rf_start,
   input  logic [$clog2(NREGS)-1:0] i_rf_lhs_sel,
   input  logic [$clog2(NREGS)-1:0] i_rf_rhs_sel,
   input  logic [$clog2(NREGS)-1:0] i_rf_dst_sel,
   input  logic                     i_rf_wr_en,
   input  logic [3:0]               i_rf_wdata,
   output logic [3:0]               o_rf_lhs,
   output logic [3:0]               o_rf_rhs,
   output logic                     o_rf_busy,
   output logic [1:0]               o_rf_ctr,
   output logic                     o_rf_ctr_last_cycle
);

   localparam int SW = $clog2(NREGS);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_ctr;
   logic [1:0]    w_ctr_nxt;
   logic          w_latch;
   logic [SW-1:0] r_lhs;
   logic [SW-1:0] r_rhs;
   logic [SW-1:0] r_dst;
   logic          r_wr_en;
   logic [15:0]   r_regs [NREGS];
   logic          w_busy;
   logic          w_wr;
   logic [3:0]    w_nib;
   logic [15:0]   w_lhs_word;
   logic [15:0]   w_rhs_word;

   assign w_busy = (r_state == ST_ACTIVE);
   assign w_nib  = {r_ctr, 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_ctr_nxt   = r_ctr;
      w_latch     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_rf_start) begin
               w_state_nxt = ST_ACTIVE;
               w_ctr_nxt   = 2'd0;
               w_latch     = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (r_ctr == 2'd3) begin
               // Last nibble: chain straight into a new window or drop to idle.
               w_ctr_nxt = 2'd0;
               if (i_rf_start) begin
                  w_latch = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_ctr_nxt = r_ctr + 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ctr_nxt   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge i_rf_gck) begin
      if (i_rf_rst) begin
         r_state <= ST_IDLE;
         r_ctr   <= 2'd0;
         r_lhs   <= '0;
         r_rhs   <= '0;
         r_dst   <= '0;
         r_wr_en <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ctr   <= w_ctr_nxt;
         if (w_latch) begin
            r_lhs   <= i_rf_lhs_sel;
            r_rhs   <= i_rf_rhs_sel;
            r_dst   <= i_rf_dst_sel;
            r_wr_en <= i_rf_wr_en;
         end
      end
   end

   // Only the nibble at the current position is written, so reads of the
   // same register at that position still see the pre-write value.
   assign w_wr = w_busy && r_wr_en && (r_dst != '0);

   always_ff @(posedge i_rf_gck) begin
      if (i_rf_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= 16'd0;
         end
      end else if (w_wr) begin
         r_regs[r_dst][w_nib +: 4] <= i_rf_wdata;
      end
   end

   assign w_lhs_word = r_regs[r_lhs];
   assign w_rhs_word = r_regs[r_rhs];

   assign o_rf_lhs = (w_busy && r_lhs != '0) ? w_lhs_word[w_nib +: 4] : 4'd0;
   assign o_rf_rhs = (w_busy && r_rhs != '0) ? w_rhs_word[w_nib +: 4] : 4'd0;

   assign o_rf_busy           = w_busy;
   assign o_rf_ctr            = r_ctr;
   assign o_rf_ctr_last_cycle = !w_busy || (r_ctr == 2'd3);

endmodule

// File: tb/tb_idli_rf_m.sv
// tb_idli_rf_m: directed scoreboard bench for idli_rf_m.
// Expected outputs are queued per stimulus cycle and checked at the negedge.
module tb_idli_rf_m;

   typedef struct packed {
      logic       busy;
      logic [1:0] ctr;
      logic       last;
      logic [3:0] lhs;
      logic [3:0] rhs;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] lsel;
   logic [2:0] rsel;
   logic [2:0] dsel;
   logic       wr_en;
   logic [3:0] wdata;
   logic [3:0] lhs;
   logic [3:0] rhs;
   logic       busy;
   logic [1:0] ctr;
   logic       last;

   logic [15:0] wword;
   obs_t        sb [$];
   int          n_vec;
   int          n_err;

   idli_rf_m #(.NREGS(8)) dut (
      .i_rf_gck            (clk),
      .i_rf_rst            (rst),
      .i_rf_start          (start),
      .i_rf_lhs_sel        (lsel),
      .i_rf_rhs_sel        (rsel),
      .i_rf_dst_sel        (dsel),
      .i_rf_wr_en          (wr_en),
      .i_rf_wdata          (wdata),
      .o_rf_lhs            (lhs),
      .o_rf_rhs            (rhs),
      .o_rf_busy           (busy),
      .o_rf_ctr            (ctr),
      .o_rf_ctr_last_cycle (last)
   );

   // Behaves like the ALU: result nibble follows the counter position.
   assign wdata = wword[{ctr, 2'b00} +: 4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic obs_t mk(input logic b, input logic [1:0] c,
                               input logic l, input logic [3:0] a,
                               input logic [3:0] r);
      obs_t o;
      o.busy = b;
      o.ctr  = c;
      o.last = l;
      o.lhs  = a;
      o.rhs  = r;
      return o;
   endfunction

   function automatic obs_t idle();
      return mk(1'b0, 2'd0, 1'b1, 4'd0, 4'd0);
   endfunction

   task automatic tick(input logic r, input logic s,
                       input logic [2:0] l, input logic [2:0] rr,
                       input logic [2:0] d, input logic w,
                       input obs_t e, input string tag);
      obs_t got;
      obs_t exp;
      sb.push_back(e);
      rst   = r;
      start = s;
      lsel  = l;
      rsel  = rr;
      dsel  = d;
      wr_en = w;
      @(posedge clk);
      @(negedge clk);
      got = {busy, ctr, last, lhs, rhs};
      exp = sb.pop_front();
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One 4-cycle window; ticks 1..3 drive unrelated selects, and with
   // hold=1 also keep start asserted (must be ignored mid-window).
   task automatic win(input logic [2:0] l, input logic [2:0] r,
                      input logic [2:0] d, input logic w,
                      input logic [15:0] wd, input logic [15:0] el,
                      input logic [15:0] er, input logic hold,
                      input string tag);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            tick(1'b0, 1'b1, l, r, d, w,
                 mk(1'b1, 2'd0, 1'b0, el[3:0], er[3:0]),
                 $sformatf("%s.n0", tag));
            wword = wd;
         end else begin
            tick(1'b0, hold, 3'd5, 3'd6, 3'd7, 1'b0,
                 mk(1'b1, 2'(k), (k == 3), el[4*k +: 4], er[4*k +: 4]),
                 $sformatf("%s.n%0d", tag, k));
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      wword = 16'($urandom);
      rst   = 1'b1;
      start = 1'b0;
      lsel  = '0;
      rsel  = '0;
      dsel  = '0;
      wr_en = 1'b0;

      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'($urandom), 3'($urandom), 3'($urandom),
              3'($urandom), 1'($urandom), idle(), "reset");
      end
      wword = 16'd0;
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle0");

      for (int i = 0; i < 8; i++) begin
         win(3'(i), 3'(7 - i), 3'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0,
             $sformatf("rdzero%0d", i));
      end
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle1");

      win(3'd0, 3'd0, 3'd1, 1'b1, 16'h1234, 16'h0, 16'h0, 1'b0, "wr_r1");
      win(3'd1, 3'd1, 3'd0, 1'b0, 16'h0, 16'h1234, 16'h1234, 1'b0, "rd_r1");

      win(3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'h1234, 16'h0, 1'b0, "wr_r0");
      win(3'd0, 3'd1, 3'd0, 1'b0, 16'h0, 16'h0, 16'h1234, 1'b0, "rd_r0");
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle2");

      win(3'd1, 3'd0, 3'd0, 1'b0, 16'h0, 16'h1234, 16'h0, 1'b1, "b2b_a");
      win(3'd0, 3'd1, 3'd0, 1'b0, 16'h0, 16'h0, 16'h1234, 1'b1, "b2b_b");
      win(3'd1, 3'd1, 3'd0, 1'b0, 16'h0, 16'h1234, 16'h1234, 1'b1, "b2b_c");
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle3");

      win(3'd0, 3'd0, 3'd2, 1'b1, 16'h000F, 16'h0, 16'h0, 1'b0, "wr_r2");
      win(3'd2, 3'd2, 3'd2, 1'b1, 16'hCDEF, 16'h000F, 16'h000F, 1'b0,
          "ovl");
      win(3'd2, 3'd1, 3'd0, 1'b0, 16'h0, 16'hCDEF, 16'h1234, 1'b0,
          "rd_r2");

      win(3'd0, 3'd0, 3'd3, 1'b1, 16'h5555, 16'h0, 16'h0, 1'b0, "wr_r3");
      win(3'd3, 3'd0, 3'd0, 1'b0, 16'h0, 16'h5555, 16'h0, 1'b0, "rd_r3");
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle4");

      tick(1'b0, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1,
           mk(1'b1, 2'd0, 1'b0, 4'h5, 4'h5), "abort.n0");
      wword = 16'hABCD;
      tick(1'b0, 1'b0, 3'd5, 3'd6, 3'd7, 1'b0,
           mk(1'b1, 2'd1, 1'b0, 4'h5, 4'h5), "abort.n1");
      tick(1'b0, 1'b0, 3'd5, 3'd6, 3'd7, 1'b0,
           mk(1'b1, 2'd2, 1'b0, 4'h5, 4'h5), "abort.n2");
      tick(1'b1, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1, idle(), "abort.rst");
      tick(1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 1'b0, idle(), "abort.idle");
      wword = 16'd0;

      win(3'd3, 3'd1, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, "rd_clr_a");
      win(3'd2, 3'd3, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, "rd_clr_b");
      tick(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, idle(), "idle5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
